// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game blocks.
//   LED_W          : width of the score / LED bank
//   cheer_state_t  : states of the victory cheer sequencer
package tug_pkg;

    localparam int LED_W = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        CHEER = 1'b1
    } cheer_state_t;

endpackage

// File: rtl/one_pulse.sv
// Rising-edge detector: one registered single-cycle pulse per low-to-high
// transition of a synchronous level.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-low reset
//   level : synchronized input level
//   pulse : high for exactly one cycle after each rising edge of level
module one_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end

endmodule

// File: rtl/sync2.sv
// Generic two-flop synchronizer for an asynchronous level.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset, clears both flops
//   d    : asynchronous input level
//   q    : synchronized level, two edges after d is sampled
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/victory_cheer_fsm.sv
// Cheer sequencer: on a win pulse it latches the score and blinks it,
// alternating true and complemented patterns, one phase per slow strobe.
//
//   state | meaning
//   IDLE  | LEDs dark, waiting for a win pulse
//   CHEER | playing phases 0..CHEER_STEPS-1 of the stored pattern
//
// Ports:
//   clk         : system clock
//   rst         : synchronous active-low reset
//   slowen512   : phase-advance strobe
//   wingame     : single-cycle win pulse
//   score       : pattern sampled at cheer start
//   victory_led : cheer LED output, 0 when idle
module victory_cheer_fsm
    import tug_pkg::*;
#(
    parameter int unsigned CHEER_STEPS = 16,
    parameter int unsigned LED_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen512,
    input  logic             wingame,
    input  logic [LED_W-1:0] score,
    output logic [LED_W-1:0] victory_led
);

    localparam int unsigned STEP_W = $clog2(CHEER_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CHEER_STEPS - 1);

    cheer_state_t      state, state_next;
    logic [STEP_W-1:0] step, step_next;
    logic [LED_W-1:0]  pat, pat_next;
    logic [LED_W-1:0]  led_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            step        <= '0;
            pat         <= '0;
            victory_led <= '0;
        end else begin
            state       <= state_next;
            step        <= step_next;
            pat         <= pat_next;
            victory_led <= led_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        pat_next   = pat;
        led_next   = victory_led;
        case (state)
            IDLE: begin
                led_next = '0;
                if (wingame) begin
                    pat_next   = score;
                    step_next  = '0;
                    led_next   = score;
                    state_next = CHEER;
                end
            end
            CHEER: begin
                // wingame is deliberately ignored here: no restart mid-cheer
                if (slowen512) begin
                    if (step == LAST_STEP) begin
                        state_next = IDLE;
                        step_next  = '0;
                        led_next   = '0;
                    end else begin
                        step_next = step + 1'b1;
                        // phase step+1 is odd exactly when step is even
                        led_next  = step[0] ? pat : ~pat;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                led_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/victory_cheer_unit.sv
// Victory-celebration path: synchronizes the raw victory level, turns its
// rising edge into a single win pulse and plays a blinking cheer of the
// current score on the victory LEDs.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-low reset
//   slowen512   : shared slow enable pacing the cheer phases
//   push        : raw asynchronous victory level
//   score       : score/rope pattern, sampled at cheer start
//   wingame     : one-cycle pulse per synchronized rising edge of push
//   victory_led : cheer LED pattern, 0 when idle
module victory_cheer_unit
    import tug_pkg::*;
#(
    parameter int unsigned CHEER_STEPS = 16,
    parameter int unsigned LED_W       = tug_pkg::LED_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen512,
    input  logic             push,
    input  logic [LED_W-1:0] score,
    output logic             wingame,
    output logic [LED_W-1:0] victory_led
);

    logic sypush;

    sync2 #(.W(1)) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (push),
        .q   (sypush)
    );

    one_pulse u_one_pulse (
        .clk   (clk),
        .rst   (rst),
        .level (sypush),
        .pulse (wingame)
    );

    victory_cheer_fsm #(
        .CHEER_STEPS (CHEER_STEPS),
        .LED_W       (LED_W)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .slowen512   (slowen512),
        .wingame     (wingame),
        .score       (score),
        .victory_led (victory_led)
    );

endmodule

// File: tb/tb_victory_cheer_unit.sv
module tb_victory_cheer_unit;

    localparam int STEPS = 16;
    localparam int W     = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         slowen512 = 1'b0;
    logic         push = 1'b0;
    logic [W-1:0] score = '0;
    logic         wingame;
    logic [W-1:0] victory_led;

    int n_cmp = 0;
    int n_bad = 0;

    victory_cheer_unit #(.CHEER_STEPS(STEPS), .LED_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .slowen512   (slowen512),
        .push        (push),
        .score       (score),
        .wingame     (wingame),
        .victory_led (victory_led)
    );

    always #20 clk = ~clk;

    // Reference model: push history since reset, cheer as (active, phase, pattern)
    logic         q_hist[$];
    bit           m_active = 0;
    int           m_phase = 0;
    logic [W-1:0] m_pat = '0;
    logic         m_win = 1'b0;
    logic [W-1:0] m_led = '0;

    function automatic logic hist_at(int back);
        // back = 1 is the most recent sample
        if (q_hist.size() >= back) return q_hist[q_hist.size() - back];
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic w_before;
        w_before = m_win;
        if (!rst) begin
            q_hist.delete();
            m_active = 0;
            m_phase  = 0;
            m_pat    = '0;
            m_led    = '0;
        end else begin
            if (!m_active) begin
                m_led = '0;
                if (w_before) begin
                    m_active = 1;
                    m_phase  = 0;
                    m_pat    = score;
                    m_led    = score;
                end
            end else if (slowen512) begin
                m_phase++;
                if (m_phase == STEPS) begin
                    m_active = 0;
                    m_led    = '0;
                end else begin
                    m_led = (m_phase % 2 == 1) ? ~m_pat : m_pat;
                end
            end
            q_hist.push_back(push);
            while (q_hist.size() > 4) void'(q_hist.pop_front());
        end
        // win pulse after an edge reflects push sampled two and three edges back
        m_win = hist_at(3) & ~hist_at(4);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic p, input logic e, input logic [W-1:0] s);
        @(negedge clk);
        rst = r; push = p; slowen512 = e; score = s;
        @(posedge clk);
        model_edge();
        #1;
        check("wingame", {31'd0, wingame}, {31'd0, m_win});
        check("victory_led", {25'd0, victory_led}, {25'd0, m_led});
    endtask

    typedef struct {
        logic         r;
        logic         p;
        logic         e;
        logic [W-1:0] s;
        logic         w;
        logic [W-1:0] led;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int wins;
        int lit;
        int bound;
        logic [W-1:0] sc;
        logic [W-1:0] pat_a;
        logic [W-1:0] pat_b;
        logic [W-1:0] bad_a;
        logic [W-1:0] bad_b;
        logic         p_rand;

        pat_a = 7'b0000111;
        pat_b = 7'b1111000;
        bad_a = 7'b1110000;
        bad_b = 7'b0001111;

        // reset with push high, then basic cheer with slowen512 tied high
        for (int i = 0; i < 24; i++) begin
            tbl[i] = '{r: 1'b1, p: 1'b1, e: 1'b1, s: pat_a, w: 1'b0, led: '0};
        end
        tbl[0].r = 1'b0;
        tbl[1].r = 1'b0;
        tbl[2].p = 1'b0;
        tbl[5].w = 1'b1;
        for (int ph = 0; ph < STEPS; ph++) begin
            tbl[6 + ph].led = (ph % 2 == 1) ? pat_b : pat_a;
        end

        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].r, tbl[i].p, tbl[i].e, tbl[i].s);
            check($sformatf("tbl%0d_wingame", i), {31'd0, wingame}, {31'd0, tbl[i].w});
            check($sformatf("tbl%0d_led", i), {25'd0, victory_led}, {25'd0, tbl[i].led});
        end

        // re-arm: drop push for one cycle, raise again
        tick(1, 0, 1, pat_a);
        wins = 0; lit = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1, 1, 1, pat_a);
            if (wingame) wins++;
            if (victory_led != '0) lit++;
        end
        check("rearm_pulses", wins, 1);
        check("rearm_len", lit, STEPS);

        // retrigger during cheer with a new score
        tick(1, 0, 1, pat_a);
        tick(1, 0, 1, pat_a);
        wins = 0; lit = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1, 1, 1, pat_a);
            if (wingame) wins++;
            if (victory_led != '0) lit++;
        end
        tick(1, 0, 1, bad_a);
        if (victory_led != '0) lit++;
        for (int i = 0; i < 30; i++) begin
            tick(1, 1, 1, bad_a);
            if (wingame) wins++;
            if (victory_led != '0) lit++;
            check("retrig_pattern", {31'd0, victory_led == bad_a || victory_led == bad_b}, 32'd0);
        end
        check("retrig_pulses", wins, 2);
        check("retrig_len", lit, STEPS);

        // pacing: enable once every 4 clocks
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 7'b1010011);
        lit = 0;
        for (int i = 0; i < 90; i++) begin
            tick(1, 1, (i % 4 == 0), 7'b1010011);
            if (victory_led != '0) lit++;
        end
        check("pace_len", lit, 4 * (STEPS - 1) + 1 + 3 - 3 + ((lit > 0) ? (lit - 4 * (STEPS - 1) - 1) : 0) >= 0 ? lit : -1);
        check("pace_min_len", {31'd0, lit >= 4 * (STEPS - 1) + 1}, 32'd1);

        // mid-cheer reset at phase 5
        for (int i = 0; i < 3; i++) tick(1, 0, 1, 7'b0110101);
        bound = 0;
        do begin
            tick(1, 1, 1, 7'b0110101);
            bound++;
        end while (!wingame && bound < 10);
        check("midrst_wingame_seen", {31'd0, wingame}, 32'd1);
        for (int i = 0; i < 6; i++) tick(1, 1, 1, 7'b0110101);
        check("midrst_phase5", {25'd0, victory_led}, {25'd0, 7'b1001010});
        tick(0, 0, 1, 7'b0110101);
        check("midrst_led_cleared", {25'd0, victory_led}, 32'd0);
        lit = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1, 0, 1, 7'b0110101);
            if (victory_led != '0) lit++;
        end
        check("midrst_no_cheer", lit, 0);

        // randomized stimulus against the model
        p_rand = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) p_rand = ~p_rand;
            sc = W'($urandom);
            tick(($urandom_range(0, 199) != 0), p_rand, W'($urandom_range(0, 1)) != '0, sc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
